// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: stage enables/flushes for load-use, branch and cache-miss hazards.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_sequencer #(
  parameter int unsigned MISS_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_lw,
  input  logic        mem_take_branch,
  input  logic        icache_busy,
  input  logic        dcache_busy,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [1:0]  state,
  output logic        timeout_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    IDROP = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_CNT = 16'(MISS_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] busy_cnt_q, busy_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic        load_use;
  logic        branch_flush;
  logic        any_busy;

  assign load_use     = ex_lw && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign branch_flush = mem_take_branch && !dcache_busy;
  assign any_busy     = icache_busy || dcache_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      busy_cnt_q    <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_cnt_q    <= busy_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Priority: dcache miss freezes everything, then branch redirect, then per-state hazards.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    state_d     = state_q;
    if (dcache_busy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mem_take_branch) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = icache_busy ? IDROP : RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (icache_busy) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            state_d    = IWAIT;
          end
        end
        IWAIT: begin
          if (icache_busy) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        IDROP: begin
          // The fetch in flight belongs to the abandoned path; drop it when it lands.
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          if (!icache_busy) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    busy_cnt_d = 16'd0;
    if (any_busy) begin
      busy_cnt_d = (busy_cnt_q == 16'hFFFF) ? busy_cnt_q : busy_cnt_q + 16'd1;
    end
    timeout_err_d = timeout_err_q || (any_busy && (busy_cnt_d == TIMEOUT_CNT));
  end

  assign state       = state_q;
  assign timeout_err = timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en)       stall_cnt_d = stall_cnt_q + 32'd1;
    if (branch_flush) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = branch_flush;
  assign stall_cnt   = 32'd0;
  assign flush_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: vector table plus multi-cycle corner sequences.
module tb_hazard_sequencer;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_lw, mem_take_branch, icache_busy, dcache_busy;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  state;
  logic        timeout_err;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_sequencer #(.MISS_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_lw(ex_lw),
    .mem_take_branch(mem_take_branch), .icache_busy(icache_busy), .dcache_busy(dcache_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .state(state), .timeout_err(timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       lw, br, ic, dc;
    logic [4:0] en;   // {pc, ifid, idex, exmem, memwb}
    logic [2:0] fl;   // {ifid, idex, exmem}
    logic [1:0] st;   // state after the edge
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic lw, input logic br, input logic ic, input logic dc,
                     input logic [4:0] en, input logic [2:0] fl, input logic [1:0] st);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.lw = lw; v.br = br; v.ic = ic; v.dc = dc;
    v.en = en; v.fl = fl; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic lw, input logic br, input logic ic, input logic dc);
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; ex_lw = lw;
    mem_take_branch = br; icache_busy = ic; dcache_busy = dc;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] en_vec();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  endfunction

  function automatic logic [2:0] fl_vec();
    return {ifid_flush, idex_flush, exmem_flush};
  endfunction

  initial begin
    int exp_stall;
    int exp_flush;

    reset = 1'b1;
    idle();

    // Reset state and RUN decode while reset is held
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    chk("rst_en", 32'(en_vec()), 32'h1F);
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("rst_ic_en", 32'(en_vec()), 32'h0F);
    chk("rst_ic_fl", 32'(fl_vec()), 32'h4);
    idle();
    cycle();
    reset = 1'b0;

    //   rs1    rs2    rd     lw    br    ic    dc    en          fl       st
    add(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 3'b000, 2'd0);
    add(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00111, 3'b010, 2'd0);
    add(5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11111, 3'b000, 2'd0);
    add(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00111, 3'b010, 2'd0);
    add(5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 3'b000, 2'd0);
    add(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'b01111, 3'b100, 2'd1);
    add(5'd4, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 5'b01111, 3'b100, 2'd1);
    add(5'd4, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11111, 3'b000, 2'd0);
    add(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11111, 3'b111, 2'd0);
    add(5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00000, 3'b000, 2'd0);
    add(5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11111, 3'b111, 2'd0);
    add(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11111, 3'b111, 2'd2);
    add(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'b01111, 3'b100, 2'd2);
    add(5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'b01111, 3'b100, 2'd0);
    add(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 3'b000, 2'd0);
    add(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 3'b000, 2'd0);
    add(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'b01111, 3'b100, 2'd1);
    add(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 3'b000, 2'd1);
    add(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11111, 3'b111, 2'd2);
    add(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01111, 3'b100, 2'd0);
    add(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 3'b000, 2'd0);

    exp_stall = 0;
    exp_flush = 0;
    foreach (tbl[i]) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].lw, tbl[i].br, tbl[i].ic, tbl[i].dc);
      #1;
      chk($sformatf("vec%0d_en", i), 32'(en_vec()), 32'(tbl[i].en));
      chk($sformatf("vec%0d_fl", i), 32'(fl_vec()), 32'(tbl[i].fl));
      if (!tbl[i].en[4]) exp_stall++;
      if (tbl[i].br && !tbl[i].dc) exp_flush++;
      cycle();
      chk($sformatf("vec%0d_st", i), 32'(state), 32'(tbl[i].st));
    end
    chk("tbl_timeout", 32'(timeout_err), 32'd0);
    chk("tbl_stall_cnt", stall_cnt, PERF_ON ? 32'(exp_stall) : 32'd0);
    chk("tbl_flush_cnt", flush_cnt, PERF_ON ? 32'(exp_flush) : 32'd0);

    // Clean restart, then two load-use stalls and one branch
    reset = 1'b1;
    #1;
    reset = 1'b0;
    chk("pulse_stall_cnt", stall_cnt, 32'd0);
    drive(5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    idle(); cycle();
    drive(5'd1, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    idle(); cycle();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    idle(); cycle();
    chk("perf_stall_cnt", stall_cnt, PERF_ON ? 32'd2 : 32'd0);
    chk("perf_flush_cnt", flush_cnt, PERF_ON ? 32'd1 : 32'd0);

    // Three-cycle icache miss from RUN
    for (int k = 0; k < 3; k++) begin
      drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      chk($sformatf("imiss%0d_pc_en", k), 32'(pc_en), 32'd0);
      chk($sformatf("imiss%0d_ifid_fl", k), 32'(ifid_flush), 32'd1);
      cycle();
      chk($sformatf("imiss%0d_state", k), 32'(state), 32'd1);
    end
    idle();
    #1;
    chk("imiss_drop_pc_en", 32'(pc_en), 32'd1);
    chk("imiss_drop_ifid_fl", 32'(ifid_flush), 32'd0);
    cycle();
    chk("imiss_drop_state", 32'(state), 32'd0);

    // dcache miss held for six cycles with MISS_TIMEOUT=4
    for (int k = 1; k <= 6; k++) begin
      drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      chk($sformatf("tmo_busy%0d", k), 32'(timeout_err), (k >= 4) ? 32'd1 : 32'd0);
    end
    idle();
    cycle();
    cycle();
    chk("tmo_sticky", 32'(timeout_err), 32'd1);
    chk("tmo_state", 32'(state), 32'd0);

    // Asynchronous reset in the middle of an icache miss
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    chk("mid_iwait_state", 32'(state), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_timeout", 32'(timeout_err), 32'd0);
    chk("async_rst_stall_cnt", stall_cnt, 32'd0);
    chk("async_rst_flush_cnt", flush_cnt, 32'd0);
    chk("async_rst_pc_en", 32'(pc_en), 32'd0);
    cycle();
    chk("held_rst_state", 32'(state), 32'd0);
    idle();
    reset = 1'b0;
    cycle();
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_en", 32'(en_vec()), 32'h1F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter MISS_TIMEOUT, default 1024, sets the consecutive busy cycles before timeout_err; legal range 1..65535.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 ex_rd  input  5  destination register of the instruction in EX.
REQ-006 ex_lw  input  1  instruction in EX is a load.
REQ-007 mem_take_branch  input  1  jump, jalr or a taken blt/bge resolved in MEM this cycle.
REQ-008 icache_busy, dcache_busy  input  1 each  level-high while the cache miss is outstanding.
REQ-009 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  stage-register load enables.
REQ-010 ifid_flush, idex_flush, exmem_flush  output  1 each  bubble insertion into IF/ID, ID/EX and EX/MEM.
REQ-011 state  output  2  FSM state: RUN=0, IWAIT=1, IDROP=2.
REQ-012 timeout_err  output  1  sticky miss-timeout flag.
REQ-013 stall_cnt, flush_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-014 Enables and flushes SHALL be combinational from the registered state and current inputs; state and counters SHALL be registered.
REQ-015 Priority (highest first) SHALL be: dcache_busy, mem_take_branch, load-use, icache_busy.
REQ-016 Any state with dcache_busy=1: all enables 0, all flushes 0, state held.
REQ-017 Default in RUN with no event: all enables 1, all flushes 0.
REQ-018 mem_take_branch (no dcache_busy), any state: all enables 1; ifid_flush, idex_flush and exmem_flush all 1; next state IDROP if icache_busy=1, else RUN.
REQ-019 Load-use: ex_lw=1, ex_rd!=0, and ex_rd equals id_rs1 or id_rs2. Applies only in RUN with no higher-priority event. Response: pc_en=0, ifid_en=0, idex_flush=1, other enables 1. Produces exactly one bubble, with no state change.
REQ-020 RUN with icache_busy=1 and no higher-priority event: pc_en=0, ifid_flush=1, other enables 1; next state IWAIT.
REQ-021 IWAIT with icache_busy=1: same outputs as REQ-020, state held. IWAIT with icache_busy=0: REQ-017 outputs, next state RUN.
REQ-022 IDROP, with or without icache_busy: pc_en=0, ifid_flush=1. When icache_busy=0, the wrong-path word SHALL be discarded and next state SHALL be RUN.
REQ-023 When a flush and its stage enable are both 1, the flush SHALL win.
REQ-024 Busy counter (16 bit): increments each cycle icache_busy or dcache_busy is 1, saturates at 65535, and clears to 0 when both are 0.
REQ-025 timeout_err SHALL set on the clock edge where the busy counter reaches MISS_TIMEOUT, and hold until reset.

Reset
REQ-026 On reset: state=RUN, busy counter=0, timeout_err=0, stall_cnt=0, flush_cnt=0. Reset takes effect immediately, mid-miss included.
REQ-027 While reset is held, outputs SHALL decode as RUN, following REQ-016..REQ-020.

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN defined: stall_cnt increments each cycle pc_en=0; flush_cnt increments each cycle REQ-018 applies; both wrap modulo 2^32.
REQ-029 Macro HAZARD_PERF_CNT_EN undefined: stall_cnt and flush_cnt SHALL be constant 0 and their counter registers SHALL NOT be built.

Verification
REQ-030 ex_lw=1, ex_rd=5, id_rs2=5, one cycle -> pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; same stimulus with ex_rd=0 -> no stall.
REQ-031 icache_busy high 3 cycles from RUN -> state IWAIT for those cycles with pc_en=0 and ifid_flush=1; on the drop cycle pc_en=1, then state RUN.
REQ-032 mem_take_branch=1 while in IWAIT with icache_busy=1 -> three flushes asserted, pc_en=1, next state IDROP. Then icache_busy low -> ifid_flush=1 that cycle, then RUN.
REQ-033 dcache_busy=1 together with mem_take_branch=1 and a load-use hit -> all enables 0, no flush. dcache_busy low next cycle -> branch flush applies.
REQ-034 MISS_TIMEOUT=4, dcache_busy held 6 cycles -> timeout_err rises after the 4th busy cycle and stays 1 after busy drops, until reset.
REQ-035 HAZARD_PERF_CNT_EN defined, 2 load-use stalls plus 1 branch -> stall_cnt=2, flush_cnt=1. Assert reset mid-IWAIT -> state=RUN, both counters 0.
